// File: rtl/mips_pkg.sv
// Shared constants and types for the MIPS core datapath: ALUFun codes,
// width defaults and the control bundle carried from ID into EX.
package mips_pkg;

  localparam int DATA_W   = 32;
  localparam int RA_W     = 5;
  localparam int ZERO_REG = 0;

  localparam logic [5:0] ALU_ADD = 6'b000000;
  localparam logic [5:0] ALU_SUB = 6'b000001;
  localparam logic [5:0] ALU_AND = 6'b011000;
  localparam logic [5:0] ALU_OR  = 6'b011110;
  localparam logic [5:0] ALU_XOR = 6'b010110;
  localparam logic [5:0] ALU_SLL = 6'b100000;
  localparam logic [5:0] ALU_SRL = 6'b100001;
  localparam logic [5:0] ALU_SRA = 6'b100011;
  localparam logic [5:0] ALU_LT  = 6'b110101;

  typedef struct packed {
    logic       valid;
    logic       regwrite;
    logic       memread;
    logic       sign;
    logic [5:0] fun;
  } ctrl_t;

  localparam ctrl_t BUBBLE_CTRL = '0;

endpackage

// File: rtl/fwd_mux.sv
// Per-operand forwarding select: EX/MEM result, then MEM/WB data, else the
// value captured in the ID/EX register. $0 and unused operands never forward.
module fwd_mux #(
  parameter int DATA_W = mips_pkg::DATA_W,
  parameter int RA_W   = mips_pkg::RA_W
) (
  input  logic [RA_W-1:0]   src,
  input  logic              use_fwd,
  input  logic [DATA_W-1:0] stored,
  input  logic              mem_regwrite,
  input  logic [RA_W-1:0]   mem_wa,
  input  logic [DATA_W-1:0] mem_result,
  input  logic              wb_regwrite,
  input  logic [RA_W-1:0]   wb_wa,
  input  logic [DATA_W-1:0] wb_data,
  output logic [DATA_W-1:0] operand
);
  import mips_pkg::*;

  logic src_live;
  logic mem_hit;
  logic wb_hit;

  // A match on src also implies the source address is nonzero.
  assign src_live = use_fwd && (src != RA_W'(ZERO_REG));
  assign mem_hit  = src_live && mem_regwrite && (mem_wa == src);
  assign wb_hit   = src_live && wb_regwrite  && (wb_wa  == src);

  always_comb begin
    operand = stored;
    if (mem_hit) begin
      operand = mem_result;
    end else if (wb_hit) begin
      operand = wb_data;
    end
  end

endmodule

// File: rtl/alu_operand_stage.sv
// ID/EX register ahead of the ALU adder: captures decoded operands/control,
// inserts load-use bubbles, honours stall/flush and forwards from MEM and WB.
module alu_operand_stage #(
  parameter int DATA_W = mips_pkg::DATA_W,
  parameter int RA_W   = mips_pkg::RA_W,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  output logic              id_ready,
  input  logic [RA_W-1:0]   id_rs,
  input  logic [RA_W-1:0]   id_rt,
  input  logic [RA_W-1:0]   id_wa,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic              id_alusrc,
  input  logic [5:0]        id_alufun,
  input  logic              id_sign,
  input  logic              id_regwrite,
  input  logic              id_memread,
  input  logic              ex_stall,
  input  logic              flush,
  input  logic              mem_regwrite,
  input  logic [RA_W-1:0]   mem_wa,
  input  logic [DATA_W-1:0] mem_result,
  input  logic              wb_regwrite,
  input  logic [RA_W-1:0]   wb_wa,
  input  logic [DATA_W-1:0] wb_data,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [5:0]        alu_fun,
  output logic              alu_sign,
  output logic              ex_valid,
  output logic              ex_regwrite,
  output logic              ex_memread,
  output logic [RA_W-1:0]   ex_wa,
  output logic [CNT_W-1:0]  bubble_cnt
);
  import mips_pkg::*;

  ctrl_t             ctrl_p0;
  logic [RA_W-1:0]   wa_p0;
  logic [RA_W-1:0]   rs_p0;
  logic [RA_W-1:0]   rt_p0;
  logic              use_rt_p0;
  logic [DATA_W-1:0] a_p0;
  logic [DATA_W-1:0] b_p0;
  logic [CNT_W-1:0]  cnt_p0;
  logic              load_use;

  // A load in EX whose destination feeds the instruction waiting in ID.
  assign load_use = ctrl_p0.valid && ctrl_p0.memread && (wa_p0 != RA_W'(ZERO_REG)) &&
                    ((wa_p0 == id_rs) || ((wa_p0 == id_rt) && !id_alusrc));

  assign id_ready = !ex_stall && !load_use;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrl_p0   <= BUBBLE_CTRL;
      wa_p0     <= '0;
      rs_p0     <= '0;
      rt_p0     <= '0;
      use_rt_p0 <= 1'b0;
      a_p0      <= '0;
      b_p0      <= '0;
      cnt_p0    <= '0;
    end else if (flush) begin
      ctrl_p0   <= BUBBLE_CTRL;
      wa_p0     <= '0;
      rs_p0     <= '0;
      rt_p0     <= '0;
      use_rt_p0 <= 1'b0;
      a_p0      <= '0;
      b_p0      <= '0;
    end else if (!ex_stall) begin
      if (load_use) begin
        ctrl_p0   <= BUBBLE_CTRL;
        wa_p0     <= '0;
        rs_p0     <= '0;
        rt_p0     <= '0;
        use_rt_p0 <= 1'b0;
        a_p0      <= '0;
        b_p0      <= '0;
        if (cnt_p0 != '1) begin
          cnt_p0 <= cnt_p0 + 1'b1;
        end
      end else begin
        ctrl_p0.valid    <= id_valid;
        ctrl_p0.regwrite <= id_valid && id_regwrite;
        ctrl_p0.memread  <= id_valid && id_memread;
        ctrl_p0.sign     <= id_valid && id_sign;
        ctrl_p0.fun      <= id_valid ? id_alufun : 6'd0;
        wa_p0            <= id_valid ? id_wa : '0;
        rs_p0            <= id_rs;
        rt_p0            <= id_rt;
        use_rt_p0        <= !id_alusrc;
        a_p0             <= id_rs_data;
        b_p0             <= id_alusrc ? id_imm : id_rt_data;
      end
    end
  end

  // ---- EX boundary: operands resolved against in-flight writers ----
  fwd_mux #(.DATA_W(DATA_W), .RA_W(RA_W)) u_fwd_a (
    .src          (rs_p0),
    .use_fwd      (1'b1),
    .stored       (a_p0),
    .mem_regwrite (mem_regwrite),
    .mem_wa       (mem_wa),
    .mem_result   (mem_result),
    .wb_regwrite  (wb_regwrite),
    .wb_wa        (wb_wa),
    .wb_data      (wb_data),
    .operand      (alu_a)
  );

  fwd_mux #(.DATA_W(DATA_W), .RA_W(RA_W)) u_fwd_b (
    .src          (rt_p0),
    .use_fwd      (use_rt_p0),
    .stored       (b_p0),
    .mem_regwrite (mem_regwrite),
    .mem_wa       (mem_wa),
    .mem_result   (mem_result),
    .wb_regwrite  (wb_regwrite),
    .wb_wa        (wb_wa),
    .wb_data      (wb_data),
    .operand      (alu_b)
  );

  assign alu_fun     = ctrl_p0.fun;
  assign alu_sign    = ctrl_p0.sign;
  assign ex_valid    = ctrl_p0.valid;
  assign ex_regwrite = ctrl_p0.regwrite;
  assign ex_memread  = ctrl_p0.memread;
  assign ex_wa       = wa_p0;
  assign bubble_cnt  = cnt_p0;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed bench for alu_operand_stage; a second instance with CNT_W=2
// shares the stimulus to exercise bubble counter saturation.
module tb_alu_operand_stage;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid;
  logic        id_ready;
  logic [4:0]  id_rs, id_rt, id_wa;
  logic [31:0] id_rs_data, id_rt_data, id_imm;
  logic        id_alusrc;
  logic [5:0]  id_alufun;
  logic        id_sign, id_regwrite, id_memread;
  logic        ex_stall, flush;
  logic        mem_regwrite;
  logic [4:0]  mem_wa;
  logic [31:0] mem_result;
  logic        wb_regwrite;
  logic [4:0]  wb_wa;
  logic [31:0] wb_data;
  logic [31:0] alu_a, alu_b;
  logic [5:0]  alu_fun;
  logic        alu_sign, ex_valid, ex_regwrite, ex_memread;
  logic [4:0]  ex_wa;
  logic [15:0] bubble_cnt;

  logic        s_id_ready;
  logic [31:0] s_alu_a, s_alu_b;
  logic [5:0]  s_alu_fun;
  logic        s_alu_sign, s_ex_valid, s_ex_regwrite, s_ex_memread;
  logic [4:0]  s_ex_wa;
  logic [1:0]  s_bubble_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_operand_stage dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_ready(id_ready),
    .id_rs(id_rs), .id_rt(id_rt), .id_wa(id_wa),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_alusrc(id_alusrc), .id_alufun(id_alufun), .id_sign(id_sign),
    .id_regwrite(id_regwrite), .id_memread(id_memread),
    .ex_stall(ex_stall), .flush(flush),
    .mem_regwrite(mem_regwrite), .mem_wa(mem_wa), .mem_result(mem_result),
    .wb_regwrite(wb_regwrite), .wb_wa(wb_wa), .wb_data(wb_data),
    .alu_a(alu_a), .alu_b(alu_b), .alu_fun(alu_fun), .alu_sign(alu_sign),
    .ex_valid(ex_valid), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
    .ex_wa(ex_wa), .bubble_cnt(bubble_cnt)
  );

  alu_operand_stage #(.CNT_W(2)) dut_small (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_ready(s_id_ready),
    .id_rs(id_rs), .id_rt(id_rt), .id_wa(id_wa),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_alusrc(id_alusrc), .id_alufun(id_alufun), .id_sign(id_sign),
    .id_regwrite(id_regwrite), .id_memread(id_memread),
    .ex_stall(ex_stall), .flush(flush),
    .mem_regwrite(mem_regwrite), .mem_wa(mem_wa), .mem_result(mem_result),
    .wb_regwrite(wb_regwrite), .wb_wa(wb_wa), .wb_data(wb_data),
    .alu_a(s_alu_a), .alu_b(s_alu_b), .alu_fun(s_alu_fun), .alu_sign(s_alu_sign),
    .ex_valid(s_ex_valid), .ex_regwrite(s_ex_regwrite), .ex_memread(s_ex_memread),
    .ex_wa(s_ex_wa), .bubble_cnt(s_bubble_cnt)
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        errors++;
        $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic id_instr(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] wa,
                          input logic [31:0] rs_d, input logic [31:0] rt_d, input logic [31:0] imm,
                          input logic alusrc, input logic [5:0] fun, input logic sgn,
                          input logic memrd);
    id_valid    = 1'b1;
    id_rs       = rs;
    id_rt       = rt;
    id_wa       = wa;
    id_rs_data  = rs_d;
    id_rt_data  = rt_d;
    id_imm      = imm;
    id_alusrc   = alusrc;
    id_alufun   = fun;
    id_sign     = sgn;
    id_regwrite = 1'b1;
    id_memread  = memrd;
  endtask

  initial begin
    reset = 1'b0;
    id_valid = 0; id_rs = 0; id_rt = 0; id_wa = 0;
    id_rs_data = 0; id_rt_data = 0; id_imm = 0; id_alusrc = 0;
    id_alufun = 0; id_sign = 0; id_regwrite = 0; id_memread = 0;
    ex_stall = 0; flush = 0;
    mem_regwrite = 0; mem_wa = 0; mem_result = 0;
    wb_regwrite = 0; wb_wa = 0; wb_data = 0;

    // Reset held
    tick(); tick();
    check("rst_alu_a", alu_a, 32'h0);
    check("rst_alu_b", alu_b, 32'h0);
    check("rst_ex_valid", {31'b0, ex_valid}, 32'h0);
    check("rst_alu_fun", {26'b0, alu_fun}, 32'h0);
    check("rst_bubble_cnt", {16'b0, bubble_cnt}, 32'h0);

    // Single add after release
    reset = 1'b1;
    id_instr(5'd1, 5'd2, 5'd4, 32'd5, 32'd7, 32'd0, 1'b0, ALU_ADD, 1'b0, 1'b0);
    #1 check("add_id_ready", {31'b0, id_ready}, 32'h1);
    tick();
    check("add_alu_a", alu_a, 32'd5);
    check("add_alu_b", alu_b, 32'd7);
    check("add_ex_valid", {31'b0, ex_valid}, 32'h1);
    check("add_ex_wa", {27'b0, ex_wa}, 32'd4);
    check("add_ex_regwrite", {31'b0, ex_regwrite}, 32'h1);

    // MEM / WB forwarding priority
    id_instr(5'd3, 5'd2, 5'd5, 32'h10, 32'h20, 32'd0, 1'b0, ALU_SUB, 1'b1, 1'b0);
    tick();
    mem_regwrite = 1; mem_wa = 5'd3; mem_result = 32'hAA;
    wb_regwrite = 1; wb_wa = 5'd3; wb_data = 32'hBB;
    #1 check("fwd_mem_a", alu_a, 32'hAA);
    check("fwd_b_untouched", alu_b, 32'h20);
    check("sub_alu_fun", {26'b0, alu_fun}, {26'b0, ALU_SUB});
    check("sub_alu_sign", {31'b0, alu_sign}, 32'h1);
    mem_regwrite = 0;
    #1 check("fwd_wb_a", alu_a, 32'hBB);
    wb_regwrite = 0;
    #1 check("fwd_none_a", alu_a, 32'h10);

    // $0 and immediates never forwarded
    id_instr(5'd0, 5'd6, 5'd7, 32'd0, 32'h33, 32'h4, 1'b1, ALU_ADD, 1'b0, 1'b0);
    tick();
    mem_regwrite = 1; mem_wa = 5'd0; mem_result = 32'hDEAD;
    #1 check("zero_reg_a", alu_a, 32'h0);
    mem_wa = 5'd6;
    #1 check("imm_b", alu_b, 32'h4);
    mem_regwrite = 0;

    // Load-use bubble
    id_instr(5'd1, 5'd0, 5'd8, 32'h100, 32'd0, 32'h8, 1'b1, ALU_ADD, 1'b0, 1'b1);
    tick();
    check("lw_ex_memread", {31'b0, ex_memread}, 32'h1);
    id_instr(5'd8, 5'd9, 5'd10, 32'h1, 32'h2, 32'd0, 1'b0, ALU_ADD, 1'b0, 1'b0);
    #1 check("lu_id_ready", {31'b0, id_ready}, 32'h0);
    tick();
    check("lu_ex_valid", {31'b0, ex_valid}, 32'h0);
    check("lu_bubble_cnt", {16'b0, bubble_cnt}, 32'd1);
    check("lu_small_cnt", {30'b0, s_bubble_cnt}, 32'd1);
    check("lu_alu_fun", {26'b0, alu_fun}, 32'h0);
    check("lu_id_ready_after", {31'b0, id_ready}, 32'h1);
    tick();
    check("lu_enter_valid", {31'b0, ex_valid}, 32'h1);
    check("lu_enter_wa", {27'b0, ex_wa}, 32'd10);
    check("lu_enter_a", alu_a, 32'h1);
    check("lu_enter_b", alu_b, 32'h2);

    // Stall holds fields, forwarding still tracks
    id_instr(5'd11, 5'd12, 5'd13, 32'h55, 32'h66, 32'd0, 1'b0, ALU_AND, 1'b0, 1'b0);
    ex_stall = 1;
    #1 check("stall_id_ready", {31'b0, id_ready}, 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_hold_wa", {27'b0, ex_wa}, 32'd10);
      check("stall_hold_a", alu_a, 32'h1);
    end
    mem_regwrite = 1; mem_wa = 5'd8; mem_result = 32'h77;
    #1 check("stall_fwd_a", alu_a, 32'h77);
    mem_regwrite = 0;
    ex_stall = 0;
    tick();
    check("unstall_wa", {27'b0, ex_wa}, 32'd13);
    check("unstall_fun", {26'b0, alu_fun}, {26'b0, ALU_AND});
    check("unstall_a", alu_a, 32'h55);

    // Flush beats stall
    ex_stall = 1; flush = 1;
    tick();
    check("flush_ex_valid", {31'b0, ex_valid}, 32'h0);
    check("flush_alu_fun", {26'b0, alu_fun}, 32'h0);
    check("flush_ex_wa", {27'b0, ex_wa}, 32'h0);
    check("flush_alu_a", alu_a, 32'h0);
    ex_stall = 0; flush = 0;

    // Flush with load-use: no count
    id_instr(5'd1, 5'd0, 5'd8, 32'h100, 32'd0, 32'h8, 1'b1, ALU_ADD, 1'b0, 1'b1);
    tick();
    id_instr(5'd8, 5'd9, 5'd10, 32'h1, 32'h2, 32'd0, 1'b0, ALU_ADD, 1'b0, 1'b0);
    flush = 1;
    #1 check("fl_lu_id_ready", {31'b0, id_ready}, 32'h0);
    tick();
    check("fl_lu_valid", {31'b0, ex_valid}, 32'h0);
    check("fl_lu_cnt", {16'b0, bubble_cnt}, 32'd1);
    flush = 0;

    // Counter saturation on the 2-bit instance
    for (int i = 0; i < 5; i++) begin
      id_instr(5'd1, 5'd0, 5'd8, 32'h100, 32'd0, 32'h8, 1'b1, ALU_ADD, 1'b0, 1'b1);
      tick();
      id_instr(5'd8, 5'd9, 5'd10, 32'h1, 32'h2, 32'd0, 1'b0, ALU_ADD, 1'b0, 1'b0);
      tick();
    end
    check("sat_small_cnt", {30'b0, s_bubble_cnt}, 32'd3);
    check("sat_main_cnt", {16'b0, bubble_cnt}, 32'd6);

    // Asynchronous reset mid-stream
    id_instr(5'd1, 5'd2, 5'd4, 32'd5, 32'd7, 32'd0, 1'b0, ALU_ADD, 1'b0, 1'b0);
    tick();
    check("pre_areset_valid", {31'b0, ex_valid}, 32'h1);
    #1 reset = 1'b0;
    #1 check("areset_valid", {31'b0, ex_valid}, 32'h0);
    check("areset_cnt", {16'b0, bubble_cnt}, 32'h0);
    check("areset_a", alu_a, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_operand_stage.md
Name: alu_operand_stage

Overview:
- ID/EX pipeline stage that sits directly upstream of the ALU adder in the pipelined MIPS core.
- Registers decoded operands and control, resolves RAW hazards by forwarding from the EX/MEM and MEM/WB stages, and inserts load-use bubbles.
- Honours stall and flush requests.
- Drives A, B, ALUFun and Sign to the adder.

Parameters:
- DATA_W, 32, operand width.
- RA_W, 5, register-address width.
- CNT_W, 16, width of the load-use bubble counter.

Ports:
- clk  in  1  core clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- id_valid  in  1  ID holds a real instruction.
- id_ready  out  1  stage accepts ID this cycle.
- id_rs, id_rt, id_wa  in  RA_W each  source and destination register numbers.
- id_rs_data, id_rt_data  in  DATA_W  register-file read data.
- id_imm  in  DATA_W  extended immediate.
- id_alusrc  in  1  1 selects id_imm as B.
- id_alufun  in  6  ALU function code.
- id_sign  in  1  signed operation.
- id_regwrite, id_memread  in  1  write-back enable; instruction is a load.
- ex_stall  in  1  downstream busy; hold stage.
- flush  in  1  kill the instruction entering EX (taken branch/jump).
- mem_regwrite, mem_wa, mem_result  in  1/RA_W/DATA_W  EX/MEM forwarding source.
- wb_regwrite, wb_wa, wb_data  in  1/RA_W/DATA_W  MEM/WB forwarding source.
- alu_a, alu_b  out  DATA_W  operands to the adder.
- alu_fun  out  6  to the adder.
- alu_sign  out  1  to the adder.
- ex_valid, ex_regwrite, ex_memread  out  1  registered control.
- ex_wa  out  RA_W  registered destination.
- bubble_cnt  out  CNT_W  saturating count of load-use bubbles.

Behaviour:
- Reset (reset=0, asynchronous):
  - All registered fields go to 0. ex_valid=0 and bubble_cnt=0.
  - alu_a and alu_b equal the forwarded value of 0, which is 0 because all forwarding enables are 0 under reset-held inputs.
- load_use (combinational): ex_valid & ex_memread & (ex_wa!=0) & (ex_wa==id_rs | (ex_wa==id_rt & ~id_alusrc)).
- id_ready = ~ex_stall & ~load_use. Combinational, no latency.
- Register update per rising edge, in strict priority order:
  1. flush=1 → load bubble (all fields 0), regardless of ex_stall.
  2. ex_stall=1 → hold every field unchanged.
  3. load_use=1 → load bubble; bubble_cnt += 1, saturating at all-ones.
  4. Otherwise → capture the id_* fields, with ex_valid=id_valid. If id_valid=0, the control fields are also zeroed.
- Bubble definition: ex_valid=0, ex_regwrite=0, ex_memread=0, alu_fun=0, alu_sign=0, ex_wa=0, operands 0.
- Stored B is id_imm when id_alusrc=1, otherwise id_rt_data. The stage also stores rs/rt numbers and a use_rt flag (~id_alusrc).
- Forwarding (combinational on registered operands, one per operand):
  - If mem_regwrite & mem_wa!=0 & mem_wa==src → mem_result.
  - Else if wb_regwrite & wb_wa!=0 & wb_wa==src → wb_data.
  - Else the stored value.
  - EX/MEM has priority over MEM/WB.
  - B is forwarded only when use_rt=1; immediates are never forwarded.
  - Register 0 is never forwarded.
- Forwarding applies while held under ex_stall, so operands track upstream writes.
- alu_fun and alu_sign are direct register outputs, with zero combinational logic between the flops and the adder.
- Latency: an instruction accepted in cycle n presents at the adder in cycle n+1.
- Simultaneous flush and load_use: flush wins; bubble_cnt does not increment.
- Reset deassertion mid-stream: the first edge after release behaves as a normal edge.

Decomposition:
- Shared package (mips_pkg) holds:
  - ALUFun code constants.
  - Register number ZERO_REG=0.
  - Width constants DATA_W and RA_W.
  - A bubble-control constant.
- One sub-module, fwd_mux: one instance per operand. Inputs are src number, use flag, stored value and both forwarding sources; output is the operand.

Test Plan:
- Reset and single add:
  - Stimulus: reset low, then release; present id_rs_data=5, id_rt_data=7, alufun=0, valid=1.
  - Required: next cycle alu_a=5, alu_b=7, ex_valid=1.
  - Required during reset: all outputs 0.
- MEM forwarding with priority:
  - Stimulus: EX holds rs=3, stored 0x10; mem_regwrite=1, mem_wa=3, mem_result=0xAA; wb_wa=3, wb_data=0xBB.
  - Required: alu_a=0xAA. With mem_regwrite=0 instead → alu_a=0xBB.
- $0 and immediate are never forwarded:
  - Stimulus: rs=0, mem_wa=0, mem_regwrite=1.
  - Required: alu_a=stored 0.
  - Stimulus: alusrc=1, imm=0x4, rt matches mem_wa.
  - Required: alu_b=0x4.
- Load-use:
  - Stimulus: EX holds lw with ex_wa=8; ID presents rs=8.
  - Required: id_ready=0; next cycle ex_valid=0 and bubble_cnt=1; following cycle the instruction enters normally.
- Stall and flush:
  - Stimulus: ex_stall=1 for 3 cycles.
  - Required: fields held and id_ready=0.
  - Stimulus: flush=1 together with ex_stall=1.
  - Required: next cycle bubble, alu_fun=0.
- Counter saturation:
  - Stimulus: CNT_W=2, 5 load-use events.
  - Required: bubble_cnt=3.
